// File: rtl/stream_mux_rr.sv
`timescale 1ns/1ps
// N-way packet mux: round-robin or fixed-priority grant held for a whole packet, registered output.
// One arbitration bubble per packet, then 1 beat/cycle; in_ready[grant] follows out_ready, never in_valid.
module stream_mux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d;

  logic [SEL_W-1:0]   winner;
  logic               any_vld;
  logic               out_free;
  logic               accept;
  logic [WIDTH-1:0]   g_data;
  logic               g_last;

  // Modular add that works for non-power-of-two channel counts.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CHANNELS) s = s - CHANNELS;
    return SEL_W'(s);
  endfunction

  always_comb begin
    winner  = '0;
    any_vld = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!any_vld) begin
        if (MODE == 1) begin
          if (in_valid[k]) begin
            any_vld = 1'b1;
            winner  = SEL_W'(k);
          end
        end else if (in_valid[wrap_add(ptr_q, k)]) begin
          any_vld = 1'b1;
          winner  = wrap_add(ptr_q, k);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    in_ready    = '0;

    out_free = !out_valid_q || out_ready;
    g_data   = in_data[grant_q*WIDTH +: WIDTH];
    g_last   = in_last[grant_q];

    // Ready is a function of lock state and downstream space only.
    if (rst_n && state_q == LOCK) in_ready[grant_q] = out_free;
    accept = (state_q == LOCK) && in_valid[grant_q] && in_ready[grant_q];

    case (state_q)
      IDLE: begin
        if (any_vld) begin
          grant_d = winner;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (accept && g_last) begin
          state_d = IDLE;
          if (MODE == 0) ptr_d = wrap_add(grant_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_free) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = g_data;
        out_last_d = g_last;
        out_sel_d  = grant_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule
